// File: rtl/move_sequencer_if.sv
// Board/turn/strobe bundle between the tic-tac-toe controller and its consumers.
// Latency: none (wires only).
// Backpressure: none; outputs are level or one-cycle strobes.
interface move_sequencer_if;
  logic        button;
  logic [8:0]  switches;
  logic [8:0]  place;
  logic [17:0] board;
  logic [1:0]  turn;
  logic        reject;
  logic        game_over;
  logic [1:0]  winner;
  logic        draw;

  modport master (
    output button, switches,
    input  place, board, turn, reject, game_over, winner, draw
  );

  modport slave (
    input  button, switches,
    output place, board, turn, reject, game_over, winner, draw
  );
endinterface

// File: rtl/move_sequencer.sv
// Tic-tac-toe game controller: debounces the button, validates and commits moves, detects win/draw.
// Latency: place 1 cycle after VALIDATE (VALIDATE is 3+DEBOUNCE_CYCLES edges after button falls), board +1, turn/result +2.
// Backpressure: none; one accepted press yields at most one move, button ignored once the game is over.
module move_sequencer #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic       clk,
  input  logic       rst,
  move_sequencer_if.slave bus
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, PRESS, VALIDATE, PLACE, CHECK, RELEASE, OVER
  } state_t;

  state_t        state, state_nx;
  logic          sync1, btn_s;
  logic [CW-1:0] cnt;
  logic [8:0]    sel_q, place_q;
  logic [17:0]   board_q;
  logic [1:0]    turn_q, winner_q;
  logic          reject_q, over_q, draw_q;

  logic [8:0]    occ, mine;
  logic          move_ok, line_done, full, cnt_done, qualify;

  // Per-cell occupancy and "owned by the player to move" flags.
  always_comb begin
    occ  = '0;
    mine = '0;
    for (int i = 0; i < 9; i++) begin
      occ[i]  = |board_q[2*i +: 2];
      mine[i] = (board_q[2*i +: 2] == turn_q);
    end
  end

  assign move_ok   = $onehot(bus.switches) && ((bus.switches & occ) == 9'd0);
  assign line_done = (&mine[2:0]) | (&mine[5:3]) | (&mine[8:6])
                   | (mine[0] & mine[3] & mine[6])
                   | (mine[1] & mine[4] & mine[7])
                   | (mine[2] & mine[5] & mine[8])
                   | (mine[0] & mine[4] & mine[8])
                   | (mine[2] & mine[4] & mine[6]);
  assign full      = &occ;
  assign cnt_done  = (cnt == CNT_LAST);
  // Counter advances only while btn_s holds the level the current state is qualifying.
  assign qualify   = ((state == PRESS) && !btn_s) || ((state == RELEASE) && btn_s);

  // Two-flop synchronizer for the asynchronous, active-low button.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b1;
      btn_s <= 1'b1;
    end else begin
      sync1 <= bus.button;
      btn_s <= sync1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (!btn_s) state_nx = PRESS;
      PRESS:    if (btn_s) state_nx = IDLE;
                else if (cnt_done) state_nx = VALIDATE;
      VALIDATE: state_nx = move_ok ? PLACE : RELEASE;
      PLACE:    state_nx = CHECK;
      CHECK:    state_nx = (line_done || full) ? OVER : RELEASE;
      RELEASE:  if (btn_s && cnt_done) state_nx = IDLE;
      OVER:     state_nx = OVER;
      default:  state_nx = IDLE;
    endcase
  end

  // Debounce counter: counts consecutive qualifying samples, clears otherwise or on completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                     cnt <= '0;
    else if (qualify && !cnt_done) cnt <= cnt + CW'(1);
    else                          cnt <= '0;
  end

  // Move datapath: selection capture, strobes, board write, result evaluation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_q    <= '0;
      place_q  <= '0;
      reject_q <= 1'b0;
      board_q  <= '0;
      turn_q   <= 2'b01;
      winner_q <= 2'b00;
      over_q   <= 1'b0;
      draw_q   <= 1'b0;
    end else begin
      place_q  <= '0;
      reject_q <= 1'b0;
      if (state == VALIDATE) begin
        sel_q <= bus.switches;
        if (move_ok) place_q  <= bus.switches;
        else         reject_q <= 1'b1;
      end
      if (state == PLACE) begin
        for (int i = 0; i < 9; i++) begin
          if (sel_q[i]) board_q[2*i +: 2] <= turn_q;
        end
      end
      if (state == CHECK) begin
        if (line_done) begin
          winner_q <= turn_q;
          over_q   <= 1'b1;
        end else if (full) begin
          draw_q   <= 1'b1;
          over_q   <= 1'b1;
        end else begin
          turn_q   <= ~turn_q;
        end
      end
    end
  end

  assign bus.place     = place_q;
  assign bus.reject    = reject_q;
  assign bus.board     = board_q;
  assign bus.turn      = turn_q;
  assign bus.winner    = winner_q;
  assign bus.game_over = over_q;
  assign bus.draw      = draw_q;

endmodule

// File: tb/tb_move_sequencer.sv
// Bench for move_sequencer: game-rule model with press-to-output latency schedule, per-cycle compare.
// Latency: model outputs change at posedge+1; compares sampled on the falling edge.
// Backpressure: n/a.
module tb_move_sequencer;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  move_sequencer_if bus();

  move_sequencer #(.DEBOUNCE_CYCLES(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Game model: cell owners, expected strobes and status.
  int         cells [9];
  logic [8:0] m_place;
  logic       m_reject, m_over, m_draw;
  logic [1:0] m_turn, m_winner;
  localparam int LN [24] = '{0,1,2, 3,4,5, 6,7,8, 0,3,6, 1,4,7, 2,5,8, 0,4,8, 2,4,6};

  int  n_checks = 0;
  int  n_fail   = 0;
  int  place_seen = 0;
  int  rej_seen   = 0;
  bit  cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [17:0] pack_board();
    logic [17:0] b;
    b = '0;
    for (int i = 0; i < 9; i++) b[2*i +: 2] = 2'(cells[i]);
    return b;
  endfunction

  function automatic bit has_line(input int p);
    bit hit;
    hit = 1'b0;
    for (int l = 0; l < 8; l++)
      if (cells[LN[3*l]] == p && cells[LN[3*l+1]] == p && cells[LN[3*l+2]] == p) hit = 1'b1;
    return hit;
  endfunction

  function automatic bit board_full();
    bit f;
    f = 1'b1;
    for (int i = 0; i < 9; i++) if (cells[i] == 0) f = 1'b0;
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 9; i++) cells[i] = 0;
    m_place = '0; m_reject = 1'b0; m_over = 1'b0; m_draw = 1'b0;
    m_turn = 2'b01; m_winner = 2'b00;
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("place",     32'(bus.place),     32'(m_place));
      chk("reject",    32'(bus.reject),    32'(m_reject));
      chk("board",     32'(bus.board),     32'(pack_board()));
      chk("turn",      32'(bus.turn),      32'(m_turn));
      chk("game_over", 32'(bus.game_over), 32'(m_over));
      chk("winner",    32'(bus.winner),    32'(m_winner));
      chk("draw",      32'(bus.draw),      32'(m_draw));
      if (bus.place != 9'd0) place_seen++;
      if (bus.reject)        rej_seen++;
    end
  end

  // One press: fall at negedge of cycle c; place/reject visible after edge c+4+D,
  // board after c+5+D, turn/result after c+6+D; then hold, release, settle.
  task automatic press(input logic [8:0] sw, input int hold);
    bit ok;
    int idx;
    @(negedge clk);
    bus.switches = sw;
    bus.button   = 1'b0;
    repeat (4 + D) @(posedge clk);
    #1;
    ok  = 1'b0;
    idx = 0;
    if (!m_over) begin
      for (int i = 0; i < 9; i++) if (sw[i]) idx = i;
      ok = ($countones(sw) == 1) && (cells[idx] == 0);
      if (ok) m_place  = sw;
      else    m_reject = 1'b1;
    end
    @(posedge clk); #1;
    m_place  = '0;
    m_reject = 1'b0;
    if (ok) cells[idx] = int'(m_turn);
    @(posedge clk); #1;
    if (ok) begin
      if (has_line(int'(m_turn))) begin
        m_winner = m_turn;
        m_over   = 1'b1;
      end else if (board_full()) begin
        m_draw = 1'b1;
        m_over = 1'b1;
      end else begin
        m_turn = 2'(3 - int'(m_turn));
      end
    end
    repeat (hold) @(negedge clk);
    bus.button = 1'b1;
    repeat (D + 6) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    bus.button = 1'b1;
    rst = 1'b0;
    model_reset();
    @(negedge clk); #1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int snap_p, snap_r;
    bus.button   = 1'b1;
    bus.switches = '0;
    model_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    @(negedge clk); #1;
    chk("rst_turn",  32'(bus.turn),  32'h1);
    chk("rst_board", 32'(bus.board), 32'h0);
    chk("rst_place", 32'(bus.place), 32'h0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Clean press on cell 4, held 100 cycles.
    press(9'h010, 100);
    chk("t1_board",  32'(bus.board), 32'h00100);
    chk("t1_turn",   32'(bus.turn),  32'h2);
    chk("t1_places", place_seen,     32'd1);

    // 3-cycle low glitch: nothing happens.
    @(negedge clk);
    bus.button = 1'b0;
    repeat (3) @(negedge clk);
    bus.button = 1'b1;
    repeat (D + 6) @(negedge clk);
    chk("glitch_place", place_seen, 32'd1);
    chk("glitch_rej",   rej_seen,   32'd0);

    // Rejects: two bits set, occupied cell, no bits set.
    press(9'h003, 10);
    chk("rej_multi", rej_seen, 32'd1);
    press(9'h010, 10);
    chk("rej_occupied", rej_seen, 32'd2);
    press(9'h000, 10);
    chk("rej_zero",  rej_seen,       32'd3);
    chk("rej_turn",  32'(bus.turn),  32'h2);
    chk("rej_board", 32'(bus.board), 32'h00100);

    // X wins on the top row.
    do_reset();
    press(9'h001, 5); press(9'h008, 5); press(9'h002, 5); press(9'h010, 5); press(9'h004, 5);
    chk("win_winner", 32'(bus.winner),    32'h1);
    chk("win_over",   32'(bus.game_over), 32'h1);
    chk("win_turn",   32'(bus.turn),      32'h1);
    snap_p = place_seen;
    snap_r = rej_seen;
    press(9'h100, 5);
    chk("over_place", place_seen, snap_p);
    chk("over_rej",   rej_seen,   snap_r);

    // Full board with no line.
    do_reset();
    press(9'h001, 5); press(9'h002, 5); press(9'h004, 5); press(9'h010, 5); press(9'h008, 5);
    press(9'h020, 5); press(9'h080, 5); press(9'h040, 5); press(9'h100, 5);
    chk("draw_board",  32'(bus.board),     32'h16A59);
    chk("draw_flag",   32'(bus.draw),      32'h1);
    chk("draw_winner", 32'(bus.winner),    32'h0);
    chk("draw_over",   32'(bus.game_over), 32'h1);

    // Reset during the PLACE cycle cuts the strobe and discards the move.
    do_reset();
    @(negedge clk);
    bus.switches = 9'h001;
    bus.button   = 1'b0;
    repeat (4 + D) @(posedge clk);
    #1;
    m_place = 9'h001;
    chk("rp_place_hi", 32'(bus.place), 32'h001);
    #2;
    bus.button = 1'b1;
    rst = 1'b0;
    model_reset();
    #1;
    chk("rp_place_cut", 32'(bus.place), 32'h0);
    chk("rp_board",     32'(bus.board), 32'h0);
    chk("rp_turn",      32'(bus.turn),  32'h1);
    @(negedge clk); #1;
    rst = 1'b1;
    repeat (D + 4) @(negedge clk);
    press(9'h001, 5);
    chk("rp_after_board", 32'(bus.board), 32'h00001);
    chk("rp_after_turn",  32'(bus.turn),  32'h2);

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
